// File: rtl/dtm_jtag_dmi.sv
// RISC-V JTAG Debug Transport Module: IEEE 1149.1 TAP with IDCODE, DTMCS and
// DMI registers, plus a valid/ready request/response handshake toward the DM.
module dtm_jtag_dmi #(
   parameter int          IR_LEN       = 5,
   parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF001,
   parameter int          ABITS        = 7
) (
   input  logic             tclk,
   input  logic             trst,
   input  logic             tms,
   input  logic             tdi,
   output logic             tdo,
   output logic             tdo_en,
   output logic             dmi_req_valid,
   input  logic             dmi_req_ready,
   output logic [ABITS-1:0] dmi_req_addr,
   output logic [31:0]      dmi_req_data,
   output logic [1:0]       dmi_req_op,
   input  logic             dmi_resp_valid,
   output logic             dmi_resp_ready,
   input  logic [31:0]      dmi_resp_data,
   input  logic [1:0]       dmi_resp_op
);
   localparam int DRW = ABITS + 34;
   localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'('h01);
   localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'('h10);
   localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'('h11);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_e;
   typedef enum logic [1:0] {SEL_BYP, SEL_IDC, SEL_DTMCS, SEL_DMI} dr_sel_e;

   tap_e              state_q, state_d;
   dr_sel_e           sel;
   logic [IR_LEN-1:0] ir_q, ir_sh_q;
   logic [DRW-1:0]    dr_q;
   logic              req_valid_q, resp_wait_q;
   logic [ABITS-1:0]  req_addr_q;
   logic [31:0]       req_data_q, resp_data_q;
   logic [1:0]        req_op_q, dmistat_q, cap_op;
   logic [31:0]       dtmcs_cap;
   logic              pending;
   logic [ABITS-1:0]  sh_addr;
   logic [31:0]       sh_data;
   logic [1:0]        sh_op;

   always_ff @(posedge tclk or negedge trst)
      if (!trst) state_q <= TLR;
      else       state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   always_comb begin
      sel = SEL_BYP;
      case (ir_q)
         IR_IDCODE: sel = SEL_IDC;
         IR_DTMCS:  sel = SEL_DTMCS;
         IR_DMI:    sel = SEL_DMI;
         default:   sel = SEL_BYP;
      endcase
   end

   assign pending   = req_valid_q | resp_wait_q;
   assign cap_op    = (dmistat_q != 2'd0) ? dmistat_q : (pending ? 2'd3 : 2'd0);
   assign dtmcs_cap = {17'd0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
   assign sh_addr   = dr_q[DRW-1:34];
   assign sh_data   = dr_q[33:2];
   assign sh_op     = dr_q[1:0];

   // Sitting in TLR keeps reloading IDCODE, which covers entry by TMS as well.
   always_ff @(posedge tclk or negedge trst)
      if (!trst) begin
         ir_q    <= IR_IDCODE;
         ir_sh_q <= '0;
      end else begin
         case (state_q)
            TLR:     ir_q    <= IR_IDCODE;
            CAP_IR:  ir_sh_q <= IR_LEN'(1);
            SH_IR:   ir_sh_q <= {tdi, ir_sh_q[IR_LEN-1:1]};
            UPD_IR:  ir_q    <= ir_sh_q;
            default: ;
         endcase
      end

   // One shared shift register; tdi enters at the MSB of the selected width.
   always_ff @(posedge tclk or negedge trst)
      if (!trst) dr_q <= '0;
      else begin
         case (state_q)
            CAP_DR:
               case (sel)
                  SEL_IDC:   dr_q <= DRW'(IDCODE_VALUE);
                  SEL_DTMCS: dr_q <= DRW'(dtmcs_cap);
                  SEL_DMI:   dr_q <= {req_addr_q, resp_data_q, cap_op};
                  default:   dr_q <= '0;
               endcase
            SH_DR:
               case (sel)
                  SEL_BYP: dr_q[0]    <= tdi;
                  SEL_DMI: dr_q       <= {tdi, dr_q[DRW-1:1]};
                  default: dr_q[31:0] <= {tdi, dr_q[31:1]};
               endcase
            default: ;
         endcase
      end

   // Later assignments win: scan-side updates override handshake completion.
   always_ff @(posedge tclk or negedge trst)
      if (!trst) begin
         req_valid_q <= 1'b0;
         resp_wait_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         req_op_q    <= '0;
         resp_data_q <= '0;
         dmistat_q   <= '0;
      end else begin
         if (req_valid_q && dmi_req_ready) begin
            req_valid_q <= 1'b0;
            resp_wait_q <= 1'b1;
         end
         if (resp_wait_q && dmi_resp_valid) begin
            resp_wait_q <= 1'b0;
            if (req_op_q == 2'd1) resp_data_q <= dmi_resp_data;
            if (dmi_resp_op == 2'd2) dmistat_q <= 2'd2;
         end
         if (state_q == CAP_DR && sel == SEL_DMI && dmistat_q == 2'd0 && pending)
            dmistat_q <= 2'd3;
         if (state_q == UPD_DR && sel == SEL_DMI && dmistat_q == 2'd0) begin
            if (pending) dmistat_q <= 2'd3;
            else if (sh_op == 2'd1 || sh_op == 2'd2) begin
               req_valid_q <= 1'b1;
               req_addr_q  <= sh_addr;
               req_data_q  <= sh_data;
               req_op_q    <= sh_op;
            end
         end
         if (state_q == UPD_DR && sel == SEL_DTMCS && (dr_q[16] || dr_q[17])) begin
            dmistat_q <= 2'd0;
            if (dr_q[17]) begin
               req_valid_q <= 1'b0;
               resp_wait_q <= 1'b0;
            end
         end
      end

   always_comb begin
      tdo = 1'b0;
      if (state_q == SH_IR)      tdo = ir_sh_q[0];
      else if (state_q == SH_DR) tdo = dr_q[0];
   end

   assign tdo_en         = (state_q == SH_IR) || (state_q == SH_DR);
   assign dmi_req_valid  = req_valid_q;
   assign dmi_req_addr   = req_addr_q;
   assign dmi_req_data   = req_data_q;
   assign dmi_req_op     = req_op_q;
   assign dmi_resp_ready = resp_wait_q;
endmodule

// File: tb/tb_dtm_jtag_dmi.sv
// Bench for dtm_jtag_dmi: directed JTAG scans and DM handshakes; expected scan
// data, requests and idle outputs are queued and checked by one monitor.
module tb_dtm_jtag_dmi;
   localparam int ABITS = 7;

   logic             tclk = 1'b0;
   logic             trst, tms, tdi, tdo, tdo_en;
   logic             dmi_req_valid, dmi_req_ready;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_data;
   logic [1:0]       dmi_req_op;
   logic             dmi_resp_valid, dmi_resp_ready;
   logic [31:0]      dmi_resp_data;
   logic [1:0]       dmi_resp_op;

   always #5 tclk = ~tclk;

   dtm_jtag_dmi #(.IR_LEN(5), .IDCODE_VALUE(32'h1BEEF001), .ABITS(ABITS)) dut (
      .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
      .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
      .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op));

   typedef struct { int width; logic [63:0] val; } scan_t;
   typedef struct packed { logic [6:0] addr; logic [31:0] data; logic [1:0] op; } req_t;
   typedef struct { logic [44:0] val; logic [44:0] mask; } idle_t;

   scan_t q_scan[$];
   string q_scan_nm[$];
   req_t  q_req[$];
   idle_t q_idle[$];

   int n_chk = 0, n_fail = 0, tmo_cnt = 0;
   bit done = 1'b0, fin = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // Monitor: collects tdo while tdo_en, checks requests and idle snapshots.
   logic [63:0] sh_val;
   int          sh_cnt, tmo_seen;
   scan_t       s_cur;
   string       s_nm;
   idle_t       i_cur;
   initial begin
      sh_val = '0; sh_cnt = 0; tmo_seen = 0;
      forever begin
         @(negedge tclk);
         if (tdo_en) begin
            if (sh_cnt < 64) sh_val[sh_cnt] = tdo;
            sh_cnt++;
         end else if (sh_cnt != 0) begin
            if (q_scan.size() == 0) chk("unexpected_scan", 64'(sh_cnt), 64'd0);
            else begin
               s_cur = q_scan.pop_front();
               s_nm  = q_scan_nm.pop_front();
               chk({s_nm, "_len"}, 64'(sh_cnt), 64'(s_cur.width));
               chk(s_nm, sh_val, s_cur.val);
            end
            sh_cnt = 0; sh_val = '0;
         end
         if (dmi_req_valid) begin
            if (q_req.size() == 0) chk("unexpected_req", 64'(dmi_req_addr), 64'h0);
            else begin
               chk("req_payload", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'(q_req[0]));
               if (dmi_req_ready) void'(q_req.pop_front());
            end
         end
         if (q_idle.size() != 0) begin
            i_cur = q_idle.pop_front();
            chk("outputs", 64'({dmi_req_valid, dmi_resp_ready, tdo, tdo_en, dmi_req_op,
                               dmi_req_addr, dmi_req_data} & i_cur.mask), 64'(i_cur.val & i_cur.mask));
         end
         if (tmo_cnt != tmo_seen) begin
            chk("handshake_timeout", 64'(tmo_cnt), 64'(tmo_seen));
            tmo_seen = tmo_cnt;
         end
         if (done && !fin) begin
            chk("queues_drained", 64'(q_scan.size() + q_req.size() + q_idle.size()), 64'd0);
            fin = 1'b1;
         end
      end
   end

   function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
      return {23'd0, a, d, o};
   endfunction

   task automatic step(input logic m, input logic d);
      tms = m; tdi = d;
      @(posedge tclk); #1;
   endtask

   task automatic tap_reset();
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic push_idle(input logic [44:0] v, input logic [44:0] m);
      idle_t s;
      s.val = v; s.mask = m;
      q_idle.push_back(s);
   endtask

   task automatic scan_ir(input logic [4:0] v);
      scan_t s;
      s.width = 5; s.val = 64'h1;
      q_scan.push_back(s); q_scan_nm.push_back("ir_capture");
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 5; i++) step(i == 4, v[i]);
      step(1, 0); step(0, 0);
   endtask

   task automatic scan_dr(input int w, input logic [63:0] v, input logic [63:0] exp, input string nm);
      scan_t s;
      s.width = w; s.val = exp;
      q_scan.push_back(s); q_scan_nm.push_back(nm);
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < w; i++) step(i == w - 1, v[i]);
      step(1, 0); step(0, 0);
   endtask

   task automatic accept();
      int n = 0;
      while (!dmi_req_valid && n < 20) begin step(0, 0); n++; end
      if (!dmi_req_valid) tmo_cnt++;
      dmi_req_ready = 1'b1; step(0, 0); dmi_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] o);
      int n = 0;
      while (!dmi_resp_ready && n < 20) begin step(0, 0); n++; end
      if (!dmi_resp_ready) tmo_cnt++;
      dmi_resp_valid = 1'b1; dmi_resp_data = d; dmi_resp_op = o;
      step(0, 0);
      dmi_resp_valid = 1'b0; dmi_resp_op = 2'd0;
   endtask

   initial begin
      trst = 1'b1; tms = 1'b1; tdi = 1'b0;
      dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_op = '0;
      #2 trst = 1'b0;
      push_idle('0, '1);
      repeat (2) @(posedge tclk);
      #1 trst = 1'b1;
      tap_reset();
      push_idle('0, '1);
      scan_dr(32, 64'd0, 64'h1BEEF001, "idcode");
      scan_ir(5'h10);
      scan_dr(32, 64'd0, 64'h00001071, "dtmcs_reset");

      // DMI write held by the DM for three cycles
      scan_ir(5'h11);
      q_req.push_back({7'h10, 32'h80000001, 2'd2});
      scan_dr(41, dmi(7'h10, 32'h80000001, 2'd2), dmi(7'h00, 32'h0, 2'd0), "dmi_cap_reset");
      repeat (3) step(0, 0);
      accept();
      push_idle({4'b0100, 41'd0}, {4'b1100, 41'd0});
      respond(32'h12345678, 2'd0);

      // DMI read with data returned
      q_req.push_back({7'h04, 32'h0, 2'd1});
      scan_dr(41, dmi(7'h04, 32'h0, 2'd1), dmi(7'h10, 32'h0, 2'd0), "dmi_cap_after_write");
      accept();
      respond(32'hDEADBEEF, 2'd0);
      scan_dr(41, 64'd0, dmi(7'h04, 32'hDEADBEEF, 2'd0), "dmi_read_data");

      // Read with response withheld: busy, then dmireset, then failed response
      q_req.push_back({7'h05, 32'h0, 2'd1});
      scan_dr(41, dmi(7'h05, 32'h0, 2'd1), dmi(7'h04, 32'hDEADBEEF, 2'd0), "dmi_cap_idle");
      accept();
      scan_dr(41, 64'd0, dmi(7'h05, 32'hDEADBEEF, 2'd3), "dmi_cap_busy");
      scan_ir(5'h10);
      scan_dr(32, 64'h00010000, 64'h00001C71, "dtmcs_busy");
      scan_dr(32, 64'd0, 64'h00001071, "dtmcs_dmireset");
      respond(32'h11112222, 2'd2);
      scan_dr(32, 64'h00010000, 64'h00001871, "dtmcs_failed");

      // dmihardreset while a request is still waiting for ready
      scan_ir(5'h11);
      q_req.push_back({7'h2A, 32'hCAFEF00D, 2'd2});
      scan_dr(41, dmi(7'h2A, 32'hCAFEF00D, 2'd2), dmi(7'h05, 32'h11112222, 2'd0), "dmi_cap_after_err");
      scan_dr(41, 64'd0, dmi(7'h2A, 32'h11112222, 2'd3), "dmi_cap_busy2");
      scan_ir(5'h10);
      scan_dr(32, 64'h00020000, 64'h00001C71, "dtmcs_pre_hardreset");
      push_idle('0, {4'b1100, 41'd0});
      q_req.delete();
      scan_dr(32, 64'd0, 64'h00001071, "dtmcs_hardreset");

      // BYPASS, undefined IR, and TMS-driven reset back to IDCODE
      scan_ir(5'h1F);
      scan_dr(8, 64'hA5, 64'h4A, "bypass");
      scan_ir(5'h05);
      scan_dr(8, 64'hA5, 64'h4A, "bypass_undef");
      tap_reset();
      scan_dr(32, 64'd0, 64'h1BEEF001, "idcode_tms_reset");

      // trst while dmi_req_valid is high
      scan_ir(5'h11);
      q_req.push_back({7'h33, 32'h0BADF00D, 2'd2});
      scan_dr(41, dmi(7'h33, 32'h0BADF00D, 2'd2), dmi(7'h2A, 32'h11112222, 2'd0), "dmi_cap_pre_trst");
      #2 trst = 1'b0;
      push_idle('0, '1);
      q_req.delete();
      step(0, 0); step(0, 0);
      trst = 1'b1;
      step(0, 0);
      scan_dr(32, 64'd0, 64'h1BEEF001, "idcode_after_trst");

      repeat (2) step(0, 0);
      done = 1'b1;
      for (int i = 0; i < 10 && !fin; i++) @(negedge tclk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
